// File: rtl/rpm_div_sched_if.sv
// Handshake/result bundle for the shared-divider RPM scheduler.
// The bench drives the master side and the scheduler uses the slave side.
interface rpm_div_sched_if #(
    parameter int DATA_WIDTH = 16
);
    logic [3:0]            req_i;
    logic [15:0]           pulse_cnt_i;
    logic [63:0]           tick_cnt_i;
    logic                  ovf_clr_i;
    logic                  rpm_valid_o;
    logic [1:0]            rpm_ch_o;
    logic [DATA_WIDTH-1:0] rpm_data_o;
    logic                  busy_o;
    logic [3:0]            ovf_o;

    modport master (
        output req_i, pulse_cnt_i, tick_cnt_i, ovf_clr_i,
        input  rpm_valid_o, rpm_ch_o, rpm_data_o, busy_o, ovf_o
    );

    modport slave (
        input  req_i, pulse_cnt_i, tick_cnt_i, ovf_clr_i,
        output rpm_valid_o, rpm_ch_o, rpm_data_o, busy_o, ovf_o
    );
endinterface

// File: rtl/rpm_div_sched.sv
// Four-channel RPM calculator: pulse*SCALE/tick through one shared
// 32-cycle restoring divider, served in round-robin order.
module rpm_div_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int SCALE      = 367647
) (
    input  logic           clk,
    input  logic           rstn,
    rpm_div_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    localparam logic [31:0] SCALE_C = 32'(SCALE);
    localparam logic [31:0] MAX_Q   = 32'((64'd1 << DATA_WIDTH) - 64'd1);

    state_t                state, state_nxt;
    logic [3:0]            pending;
    logic [3:0]            pulse_hold [4];
    logic [15:0]           tick_hold  [4];
    logic [1:0]            last_ch;
    logic [1:0]            grant_ch;
    logic [1:0]            pick_ch;
    logic                  pick_vld;
    logic                  grant;
    logic [3:0]            grant_mask;
    logic [3:0]            op_pulse;
    logic [15:0]           op_tick;
    logic [31:0]           quot;
    logic [31:0]           rem;
    logic [31:0]           divisor;
    logic [32:0]           rem_shift;
    logic                  rem_ge;
    logic [4:0]            bit_cnt;
    logic                  valid_q;
    logic [1:0]            ch_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            ovf_q;

    // Scanning offsets from far to near lets the nearest pending channel after last_ch win.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[last_ch + 2'(i) + 2'd1]) begin
                pick_vld = 1'b1;
                pick_ch  = last_ch + 2'(i) + 2'd1;
            end
        end
    end

    assign grant      = (state == IDLE) && pick_vld;
    assign grant_mask = grant ? (4'b0001 << pick_ch) : 4'b0000;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = LOAD;
            LOAD:    state_nxt = (op_tick == 16'd0) ? DONE : DIV;
            DIV:     if (bit_cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A request for the channel being granted re-arms pending without counting as overrun.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= 4'd0;
            ovf_q   <= 4'd0;
            for (int c = 0; c < 4; c++) begin
                pulse_hold[c] <= 4'd0;
                tick_hold[c]  <= 16'd0;
            end
        end else begin
            pending <= (pending & ~grant_mask) | bus.req_i;
            ovf_q   <= (ovf_q & ~{4{bus.ovf_clr_i}}) | (bus.req_i & pending & ~grant_mask);
            for (int c = 0; c < 4; c++) begin
                if (bus.req_i[c]) begin
                    pulse_hold[c] <= bus.pulse_cnt_i[4*c +: 4];
                    tick_hold[c]  <= bus.tick_cnt_i[16*c +: 16];
                end
            end
        end
    end

    assign rem_shift = {rem, quot[31]};
    assign rem_ge    = rem_shift >= {1'b0, divisor};

    // quot starts as the dividend and fills with quotient bits as it shifts left.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_ch <= 2'd0;
            last_ch  <= 2'd3;
            op_pulse <= 4'd0;
            op_tick  <= 16'd0;
            quot     <= 32'd0;
            rem      <= 32'd0;
            divisor  <= 32'd0;
            bit_cnt  <= 5'd0;
            valid_q  <= 1'b0;
            ch_q     <= 2'd0;
            data_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_ch <= pick_ch;
                        op_pulse <= pulse_hold[pick_ch];
                        op_tick  <= tick_hold[pick_ch];
                    end
                end
                LOAD: begin
                    quot    <= 32'({28'd0, op_pulse} * SCALE_C);
                    divisor <= {16'd0, op_tick};
                    rem     <= 32'd0;
                    bit_cnt <= 5'd0;
                end
                DIV: begin
                    rem     <= rem_ge ? 32'(rem_shift - {1'b0, divisor}) : rem_shift[31:0];
                    quot    <= {quot[30:0], rem_ge};
                    bit_cnt <= bit_cnt + 5'd1;
                end
                DONE: begin
                    valid_q <= 1'b1;
                    ch_q    <= grant_ch;
                    last_ch <= grant_ch;
                    data_q  <= ((op_tick == 16'd0) || (quot > MAX_Q)) ? '1 : quot[DATA_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.rpm_valid_o = valid_q;
    assign bus.rpm_ch_o    = ch_q;
    assign bus.rpm_data_o  = data_q;
    assign bus.busy_o      = (state != IDLE);
    assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_rpm_div_sched.sv
// Directed bench for rpm_div_sched: a transaction-level model checked every
// cycle, plus hand-computed result, latency and flag expectations.
module tb_rpm_div_sched;
    localparam int DW    = 16;
    localparam int SCALE = 367647;
    localparam int MAXV  = (1 << DW) - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    rpm_div_sched_if #(.DATA_WIDTH(DW)) bus ();

    rpm_div_sched #(.DATA_WIDTH(DW), .SCALE(SCALE)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vec_count  = 0;
    int miss_count = 0;

    int stim_pulse [4];
    int stim_tick  [4];

    // Transaction-level model: pending set, held operands and a server with a completion countdown.
    bit [3:0] m_pend;
    bit [3:0] m_ovf;
    int       m_hp [4];
    int       m_ht [4];
    int       m_last;
    bit       m_active;
    int       m_cnt;
    int       m_ch;
    int       m_res;
    bit       m_valid;
    int       m_out_ch;
    int       m_out_data;

    task automatic checkOutput(input string name, input int act, input int exp);
        vec_count++;
        if (act != exp) begin
            miss_count++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int expected_rpm(input int p, input int t);
        longint q;
        if (t == 0) return MAXV;
        q = (longint'(p) * SCALE) / t;
        return (q > MAXV) ? MAXV : int'(q);
    endfunction

    task automatic model_reset();
        m_pend = 4'd0; m_ovf = 4'd0; m_last = 3; m_active = 1'b0; m_cnt = 0;
        m_ch = 0; m_res = 0; m_valid = 1'b0; m_out_ch = 0; m_out_data = 0;
        for (int c = 0; c < 4; c++) begin
            m_hp[c] = 0;
            m_ht[c] = 0;
        end
    endtask

    task automatic model_step();
        bit [3:0] ovf_set;
        bit       found;
        if (!rstn) begin
            model_reset();
            return;
        end
        m_valid = 1'b0;
        ovf_set = 4'd0;
        found   = 1'b0;
        if (m_active) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid    = 1'b1;
                m_out_ch   = m_ch;
                m_out_data = m_res;
                m_last     = m_ch;
                m_active   = 1'b0;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (!found && m_pend[(m_last + k) % 4]) begin
                    found    = 1'b1;
                    m_ch     = (m_last + k) % 4;
                    m_res    = expected_rpm(m_hp[m_ch], m_ht[m_ch]);
                    m_cnt    = (m_ht[m_ch] == 0) ? 2 : 34;
                    m_active = 1'b1;
                    m_pend[m_ch] = 1'b0;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (bus.req_i[c]) begin
                if (m_pend[c]) ovf_set[c] = 1'b1;
                m_pend[c] = 1'b1;
                m_hp[c]   = int'(bus.pulse_cnt_i[4*c +: 4]);
                m_ht[c]   = int'(bus.tick_cnt_i[16*c +: 16]);
            end
        end
        m_ovf = (bus.ovf_clr_i ? 4'd0 : m_ovf) | ovf_set;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        checkOutput("model_valid", int'(bus.rpm_valid_o), int'(m_valid));
        checkOutput("model_ch",    int'(bus.rpm_ch_o),    m_out_ch);
        checkOutput("model_data",  int'(bus.rpm_data_o),  m_out_data);
        checkOutput("model_busy",  int'(bus.busy_o),      int'(m_active));
        checkOutput("model_ovf",   int'(bus.ovf_o),       int'(m_ovf));
    end

    task automatic set_ch(input int c, input int p, input int t);
        stim_pulse[c] = p;
        stim_tick[c]  = t;
    endtask

    // Caller is at a falling edge; returns 2 time units after the sampling edge.
    task automatic applyStimulus(input bit [3:0] req, input bit clr);
        for (int c = 0; c < 4; c++) begin
            bus.pulse_cnt_i[4*c +: 4]  = 4'(stim_pulse[c]);
            bus.tick_cnt_i[16*c +: 16] = 16'(stim_tick[c]);
        end
        bus.req_i     = req;
        bus.ovf_clr_i = clr;
        @(posedge clk);
        #2;
        bus.req_i     = 4'd0;
        bus.ovf_clr_i = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int n);
        bit done;
        n    = start;
        done = 1'b0;
        while (!done) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.rpm_valid_o) begin
                done = 1'b1;
            end else if (n > 80) begin
                checkOutput("valid_timeout", n, 0);
                done = 1'b1;
            end
        end
    endtask

    task automatic expect_result(input string name, input int start, input int exp_n,
                                 input int exp_ch, input int exp_data);
        int n;
        wait_valid(start, n);
        if (exp_n > 0) checkOutput({name, "_edges"}, n, exp_n);
        checkOutput({name, "_ch"},   int'(bus.rpm_ch_o),   exp_ch);
        checkOutput({name, "_data"}, int'(bus.rpm_data_o), exp_data);
    endtask

    initial begin
        model_reset();
        bus.req_i       = 4'd0;
        bus.pulse_cnt_i = 16'd0;
        bus.tick_cnt_i  = 64'd0;
        bus.ovf_clr_i   = 1'b0;
        for (int c = 0; c < 4; c++) set_ch(c, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", int'(bus.rpm_valid_o), 0);
        checkOutput("reset_busy",  int'(bus.busy_o),      0);
        checkOutput("reset_ovf",   int'(bus.ovf_o),       0);

        // Request on the very first edge after reset release.
        @(negedge clk);
        rstn = 1'b1;
        set_ch(1, 4, 8193);
        applyStimulus(4'b0010, 1'b0);
        expect_result("single_ch1", 1, 36, 1, 179);

        @(negedge clk);
        set_ch(0, 4, 10);
        applyStimulus(4'b0001, 1'b0);
        expect_result("sat_ch0", 1, 36, 0, 16'hFFFF);

        @(negedge clk);
        set_ch(2, 3, 0);
        applyStimulus(4'b0100, 1'b0);
        expect_result("zero_ch2", 1, 4, 2, 16'hFFFF);

        // Fresh reset so last-served is ch3 and the sweep starts at ch0.
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        set_ch(0, 1, 100);
        set_ch(1, 2, 1000);
        set_ch(2, 3, 65535);
        set_ch(3, 15, 40000);
        applyStimulus(4'b1111, 1'b0);
        expect_result("rr_ch0", 1, 36, 0, 3676);
        expect_result("rr_ch1", 0, 35, 1, 735);
        expect_result("rr_ch2", 0, 35, 2, 16);
        expect_result("rr_ch3", 0, 35, 3, 137);

        @(negedge clk);
        applyStimulus(4'b1001, 1'b0);
        expect_result("rr30_ch0", 1, 36, 0, 3676);
        expect_result("rr30_ch3", 0, 35, 3, 137);

        @(negedge clk);
        set_ch(0, 4, 8193);
        applyStimulus(4'b0001, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_ch(2, 1, 100);
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        set_ch(2, 2, 1000);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("ovr_flag", int'(bus.ovf_o), 4);
        expect_result("ovr_ch0", 0, 0, 0, 179);
        expect_result("ovr_ch2", 0, 35, 2, 735);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("ovr_clear", int'(bus.ovf_o), 0);

        // Re-request ch1 exactly on its grant edge.
        @(negedge clk);
        set_ch(1, 4, 8193);
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        set_ch(1, 2, 1000);
        applyStimulus(4'b0010, 1'b0);
        expect_result("gedge_first", 2, 36, 1, 179);
        expect_result("gedge_second", 0, 35, 1, 735);
        checkOutput("gedge_ovf", int'(bus.ovf_o), 0);

        @(negedge clk);
        set_ch(1, 4, 8193);
        applyStimulus(4'b0010, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("abort_valid", int'(bus.rpm_valid_o), 0);
        checkOutput("abort_ch",    int'(bus.rpm_ch_o),    0);
        checkOutput("abort_data",  int'(bus.rpm_data_o),  0);
        checkOutput("abort_busy",  int'(bus.busy_o),      0);
        checkOutput("abort_ovf",   int'(bus.ovf_o),       0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        set_ch(2, 4, 8193);
        applyStimulus(4'b0100, 1'b0);
        expect_result("after_abort_ch2", 1, 36, 2, 179);

        repeat (5) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule

// File: doc/rpm_div_sched.md
RPM_DIV_SCHED -- requirements
Module: rpm_div_sched

Interface
REQ-001 Parameter: DATA_WIDTH, 16, width of rpm_data_o.
REQ-002 Parameter: SCALE, 367647, 32-bit speed scale constant.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_i  input  4  per-channel measurement-ready strobe, one cycle per request.
REQ-006 Port: pulse_cnt_i  input  4x4 (16, ch0 in [3:0])  per-channel encoder edge count.
REQ-007 Port: tick_cnt_i  input  4x16 (64, ch0 in [15:0])  per-channel gate-time clock count.
REQ-008 Port: ovf_clr_i  input  1  clears all ovf_o bits.
REQ-009 Port: rpm_valid_o  output  1  one-cycle result strobe.
REQ-010 Port: rpm_ch_o  output  2  channel index of current result.
REQ-011 Port: rpm_data_o  output  DATA_WIDTH  result = pulse*SCALE/tick, saturated.
REQ-012 Port: busy_o  output  1  high whenever FSM is not IDLE.
REQ-013 Port: ovf_o  output  4  sticky per-channel request-overrun flags.

Function
REQ-014 Block SHALL share one iterative 32-bit unsigned divider among four channels.
REQ-015 On req_i[c]=1, block SHALL copy pulse_cnt_i[c] and tick_cnt_i[c] into channel c's holding registers and set pending[c] at that edge.
REQ-016 If pending[c] is already set at that edge, block SHALL overwrite the holding registers (latest wins) and set ovf_o[c].
REQ-017 ovf_o SHALL hold until ovf_clr_i=1; if a new overrun and ovf_clr_i coincide, the overrun SHALL win for that bit.
REQ-018 FSM states: IDLE, LOAD, DIV, DONE.
REQ-019 IDLE: if any pending bit is set, block SHALL grant the first pending channel in round-robin order, starting at last-served+1 mod 4 (ch0 first after reset), clear that pending bit, and go to LOAD.
REQ-020 A req_i for the granted channel on the grant edge SHALL set pending again and SHALL NOT set ovf_o.
REQ-021 LOAD: block SHALL form dividend = {28'b0,pulse}*SCALE (32 bit) and divisor = {16'b0,tick}, then go to DIV, or go directly to DONE when tick==0.
REQ-022 DIV: restoring division, one quotient bit per cycle, exactly 32 cycles, then DONE.
REQ-023 DONE: rpm_valid_o=1 for one cycle with rpm_ch_o=granted channel; block SHALL update last-served and return to IDLE.
REQ-024 If the quotient exceeds 2^DATA_WIDTH-1 or tick==0, rpm_data_o SHALL equal all ones; otherwise it SHALL equal the truncated quotient.
REQ-025 rpm_data_o and rpm_ch_o SHALL hold their last values between strobes.
REQ-026 Latency: with the block idle and one request, rpm_valid_o SHALL go high 36 edges after the req_i sampling edge (1 pending, 1 IDLE, 1 LOAD, 32 DIV, 1 DONE); with tick==0 it SHALL go high after 4 edges.
REQ-027 Throughput: back-to-back pending channels SHALL be served every 35 cycles with no idle gap beyond the IDLE cycle.
REQ-028 Inputs SHALL be treated as synchronous to clk; the block SHALL NOT perform synchronization.

Reset
REQ-029 On rstn=0, immediately: state=IDLE, pending=0, holding registers=0, last-served=3, ovf_o=0, rpm_valid_o=0, rpm_ch_o=0, rpm_data_o=0, busy_o=0.
REQ-030 Reset mid-DIV SHALL abort the computation with no rpm_valid_o pulse after release.
REQ-031 After rstn deasserts, the first edge SHALL already accept req_i.

Verification
REQ-032 Single: ch1 pulse=4, tick=8193 -> 36 edges later rpm_valid_o=1, rpm_ch_o=1, rpm_data_o=179 (1470588/8193).
REQ-033 Saturation/zero: ch0 pulse=4, tick=10 -> data=16'hFFFF; ch2 tick=0 -> data=16'hFFFF after 4 edges, no DIV state.
REQ-034 Arbitration: req_i=4'b1111 in one cycle -> four results in order ch0,1,2,3, 35 cycles apart; then req ch3 and ch0 together -> ch0 served first (after last-served=3).
REQ-035 Overrun: ch2 requested twice while ch0 is dividing -> ovf_o=4'b0100, ch2 result uses the second operands; ovf_clr_i -> ovf_o=0.
REQ-036 Reset: rstn pulsed low at DIV cycle 10 -> all outputs 0, no valid strobe; fresh request afterwards completes normally.
REQ-037 Grant-edge request: req ch1 on its grant edge -> two ch1 results, ovf_o[1]=0.
